if_fetch_unit: RTL

- Instruction-fetch stage controller; the producer side of the IF/ID pipeline register.
- Owns the PC and runs a req/ack handshake with instruction memory.
- Delivers {PC_4, DO} plus the enableIF/resetIF controls the IF/ID register consumes.
- Handles hazard-unit stalls and branch/jump redirects from ID, discarding in-flight fetches on redirect.

---
 rtl/if_pkg.sv | 24 ++
 rtl/if_pc_reg.sv | 50 +++++
 rtl/if_fetch_unit.sv | 120 ++++++++++++
 3 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   if_state_e : fetch FSM states (request outstanding, word held, squashed fetch pending)
//   OP_J/OP_JAL: primary opcodes recognised by the optional jump predecoder
//   INSTR_W    : instruction word width
//   PC_INC     : sequential PC step in bytes
package if_pkg;

  typedef enum logic [1:0] {
    StReq,
    StHold,
    StDiscard
  } if_state_e;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_INC  = 4;

  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;

  function automatic logic is_jump(input logic [5:0] opcode);
    return (opcode == OP_J) || (opcode == OP_JAL);
  endfunction

endpackage

// File: rtl/if_pc_reg.sv
// Program-counter register for the fetch stage.
// Ports:
//   clk_i, rst_ni   : clock, asynchronous active-low reset (loads RESET_PC)
//   advance_i       : step to the next fetch address (sequential or predecoded jump)
//   jump_i          : with advance_i, take jump_pc_i instead of pc+4
//   jump_pc_i       : predecoded jump target
//   redirect_i      : external redirect, highest priority
//   redirect_pc_i   : redirect target, word-aligned on load
//   pc_o            : current PC
//   pc_inc_o        : pc_o + 4, modulo 2^AW
module if_pc_reg
  import if_pkg::*;
#(
  parameter int unsigned   AW       = 32,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          advance_i,
  input  logic          jump_i,
  input  logic [AW-1:0] jump_pc_i,
  input  logic          redirect_i,
  input  logic [AW-1:0] redirect_pc_i,
  output logic [AW-1:0] pc_o,
  output logic [AW-1:0] pc_inc_o
);

  logic [AW-1:0] pc_d, pc_q;

  assign pc_inc_o = pc_q + AW'(PC_INC);
  assign pc_o     = pc_q;

  always_comb begin
    pc_d = pc_q;
    if (redirect_i) begin
      pc_d = redirect_pc_i & ~AW'(3);
    end else if (advance_i) begin
      pc_d = jump_i ? jump_pc_i : pc_inc_o;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage controller: owns the PC, runs the req/ack handshake with
// instruction memory and feeds the IF/ID pipeline register.
// Ports:
//   reloj, resetn        : clock, asynchronous active-low reset
//   stall_if             : hazard stall, IF/ID holds its contents
//   redirect, redirect_pc: branch/jump taken in ID, flush and refetch at redirect_pc
//   imem_req, imem_addr  : fetch request/address, held stable until imem_ack
//   imem_ack, imem_rdata : memory response
//   PC_4, DO             : PC+4 and instruction word offered to IF/ID
//   enableIF, resetIF    : IF/ID load enable and synchronous clear
// Build option: IF_PREDECODE_JUMP_EN redirects the PC to J/JAL targets at handoff.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter int unsigned   AW       = 32,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic               reloj,
  input  logic               resetn,
  input  logic               stall_if,
  input  logic               redirect,
  input  logic [AW-1:0]      redirect_pc,
  output logic               imem_req,
  output logic [AW-1:0]      imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [AW-1:0]      PC_4,
  output logic [INSTR_W-1:0] DO,
  output logic               enableIF,
  output logic               resetIF
);

  if_state_e          state_d, state_q;
  logic [AW-1:0]      old_addr_d, old_addr_q;
  logic [AW-1:0]      pc4_q;
  logic [INSTR_W-1:0] do_q;
  logic [AW-1:0]      pc, pc_inc, jump_pc;
  logic               load_buf, handoff, jump;

`ifdef IF_PREDECODE_JUMP_EN
  assign jump    = is_jump(do_q[31:26]);
  assign jump_pc = {pc4_q[AW-1:28], do_q[25:0], 2'b00};
`else
  assign jump    = 1'b0;
  assign jump_pc = '0;
`endif

  if_pc_reg #(
    .AW       (AW),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk_i         (reloj),
    .rst_ni        (resetn),
    .advance_i     (handoff),
    .jump_i        (jump),
    .jump_pc_i     (jump_pc),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .pc_o          (pc),
    .pc_inc_o      (pc_inc)
  );

  always_comb begin
    state_d    = state_q;
    old_addr_d = old_addr_q;
    load_buf   = 1'b0;
    handoff    = 1'b0;
    unique case (state_q)
      StReq: begin
        if (redirect) begin
          // An unacked request must still complete at its old address; remember it.
          if (!imem_ack) begin
            state_d    = StDiscard;
            old_addr_d = pc;
          end
        end else if (imem_ack) begin
          load_buf = 1'b1;
          state_d  = StHold;
        end
      end
      StHold: begin
        if (redirect) begin
          state_d = StReq;
        end else if (!stall_if) begin
          handoff = 1'b1;
          state_d = StReq;
        end
      end
      StDiscard: begin
        if (imem_ack) state_d = StReq;
      end
      default: state_d = StReq;
    endcase
  end

  assign imem_req  = resetn && (state_q != StHold);
  assign imem_addr = (state_q == StDiscard) ? old_addr_q : pc;
  assign PC_4      = pc4_q;
  assign DO        = do_q;
  assign enableIF  = handoff;
  // Bubble whenever ID is free to advance but nothing valid is handed over.
  assign resetIF   = !resetn || redirect || (!stall_if && !handoff);

  always_ff @(posedge reloj or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StReq;
      old_addr_q <= '0;
      pc4_q      <= '0;
      do_q       <= '0;
    end else begin
      state_q    <= state_d;
      old_addr_q <= old_addr_d;
      if (load_buf) begin
        pc4_q <= pc_inc;
        do_q  <= imem_rdata;
      end
    end
  end

endmodule
